fetch_tile_sequencer: RTL and testbench

Command-driven sequencer directly upstream of the BRAM fetch-logic stage. It accepts one "fetch N tiles from buffer X" command and converts it into the single-cycle `start_fetch` / `reset_addr_counter` pulses, plus the stable `Buffer_Select` / `Tiles_Control` levels, that the fetch stage needs. It tracks how many fetched tiles are still unconsumed by the downstream compute array, and stalls issue when the ping-pong tile storage is full. It reports per-tile and per-command completion.

---
 rtl/fetch_tile_sequencer_if.sv | 30 +++
 rtl/fetch_tile_sequencer.sv | 122 ++++++++++++
 tb/tb_fetch_tile_sequencer.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_tile_sequencer_if.sv
// Command channel into fetch_tile_sequencer: one "fetch N tiles from buffer X"
// request per valid/ready handshake.
interface fetch_tile_sequencer_if #(
  parameter int unsigned TILE_CNT_WIDTH = 10
);
  logic                      cmd_valid;
  logic                      cmd_ready;
  logic [2:0]                cmd_buffer_sel;
  logic                      cmd_tiles_ctrl;
  logic [TILE_CNT_WIDTH-1:0] cmd_num_tiles;
  logic                      cmd_reset_ptr;

  modport master (
    output cmd_valid,
    output cmd_buffer_sel,
    output cmd_tiles_ctrl,
    output cmd_num_tiles,
    output cmd_reset_ptr,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_buffer_sel,
    input  cmd_tiles_ctrl,
    input  cmd_num_tiles,
    input  cmd_reset_ptr,
    output cmd_ready
  );
endinterface

// File: rtl/fetch_tile_sequencer.sv
// Turns a tile-fetch command into start/reset pulses for the BRAM fetch stage,
// throttled by how many fetched tiles the compute array has not yet consumed.
module fetch_tile_sequencer #(
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter int unsigned TILE_CNT_WIDTH  = 10
) (
  input  logic                      clk,
  input  logic                      rst_n,
  fetch_tile_sequencer_if.slave     cmd,
  output logic                      start_fetch,
  output logic                      reset_addr_counter,
  output logic [2:0]                Buffer_Select,
  output logic                      Tiles_Control,
  input  logic                      fetch_done,
  input  logic                      fetch_busy,
  output logic                      tile_fetched,
  output logic [TILE_CNT_WIDTH-1:0] tile_idx,
  input  logic                      tile_consumed,
  output logic                      seq_busy,
  output logic                      seq_done,
  output logic [1:0]                err
);

  localparam logic [2:0] MAX_OUT = 3'(MAX_OUTSTANDING);

  typedef enum logic [2:0] {
    IDLE,
    RESET_PTR,
    ISSUE,
    WAIT_DONE,
    DRAIN,
    FINISH
  } state_t;

  state_t                    state;
  logic [2:0]                outstanding;
  logic [TILE_CNT_WIDTH-1:0] issued;
  logic [TILE_CNT_WIDTH-1:0] issued_nxt;
  logic [TILE_CNT_WIDTH-1:0] num_tiles;
  logic                      consume_ok;

  // Pulses are decoded from registered state/counters so that a same-cycle
  // ISSUE exit keeps the tile period at fetch latency + 2.
  assign start_fetch        = (state == ISSUE) && (outstanding < MAX_OUT) && !fetch_busy;
  assign reset_addr_counter = (state == RESET_PTR);
  assign seq_done           = (state == FINISH);
  assign seq_busy           = (state != IDLE);
  assign cmd.cmd_ready      = (state == IDLE);

  assign consume_ok = tile_consumed && (outstanding != '0);
  assign issued_nxt = TILE_CNT_WIDTH'(issued + 1'b1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      outstanding   <= '0;
      issued        <= '0;
      num_tiles     <= '0;
      Buffer_Select <= '0;
      Tiles_Control <= 1'b0;
      tile_fetched  <= 1'b0;
      tile_idx      <= '0;
      err           <= '0;
    end else begin
      tile_fetched <= 1'b0;

      if (fetch_done && (state != WAIT_DONE)) begin
        err[0] <= 1'b1;
      end
      if (tile_consumed && (outstanding == '0)) begin
        err[1] <= 1'b1;
      end

      // Issue and consume in the same cycle cancel out.
      case ({start_fetch, consume_ok})
        2'b10:   outstanding <= outstanding + 3'd1;
        2'b01:   outstanding <= outstanding - 3'd1;
        default: outstanding <= outstanding;
      endcase

      case (state)
        IDLE: begin
          if (cmd.cmd_valid) begin
            Buffer_Select <= cmd.cmd_buffer_sel;
            Tiles_Control <= cmd.cmd_tiles_ctrl;
            num_tiles     <= cmd.cmd_num_tiles;
            issued        <= '0;
            if (cmd.cmd_num_tiles == '0) begin
              state <= FINISH;
            end else if (cmd.cmd_reset_ptr) begin
              state <= RESET_PTR;
            end else begin
              state <= ISSUE;
            end
          end
        end
        RESET_PTR: state <= ISSUE;
        ISSUE: begin
          if (start_fetch) begin
            state <= WAIT_DONE;
          end
        end
        WAIT_DONE: begin
          if (fetch_done) begin
            tile_fetched <= 1'b1;
            tile_idx     <= issued;
            issued       <= issued_nxt;
            state        <= (issued_nxt == num_tiles) ? DRAIN : ISSUE;
          end
        end
        DRAIN: begin
          if (outstanding == '0) begin
            state <= FINISH;
          end
        end
        FINISH:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_tile_sequencer.sv
// Directed bench for fetch_tile_sequencer with a behavioural fetch stage and
// consumer driven cycle by cycle from the main sequence.
module tb_fetch_tile_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start_fetch, reset_addr_counter, Tiles_Control;
  logic [2:0] Buffer_Select;
  logic       fetch_done, fetch_busy, tile_fetched, tile_consumed;
  logic [9:0] tile_idx;
  logic       seq_busy, seq_done;
  logic [1:0] err;

  fetch_tile_sequencer_if #(.TILE_CNT_WIDTH(10)) bus ();

  fetch_tile_sequencer #(
    .MAX_OUTSTANDING(2),
    .TILE_CNT_WIDTH (10)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .cmd               (bus.slave),
    .start_fetch       (start_fetch),
    .reset_addr_counter(reset_addr_counter),
    .Buffer_Select     (Buffer_Select),
    .Tiles_Control     (Tiles_Control),
    .fetch_done        (fetch_done),
    .fetch_busy        (fetch_busy),
    .tile_fetched      (tile_fetched),
    .tile_idx          (tile_idx),
    .tile_consumed     (tile_consumed),
    .seq_busy          (seq_busy),
    .seq_done          (seq_done),
    .err               (err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // environment model state
  int cyc = 0;
  int done_at = -1, busy_until = -1, spur_at = -1, consume_at = -1;
  int ack_q[$];
  int pend_consume = 0;
  int ack_delay = 5;
  int n_rd = 32;
  bit auto_ack = 1'b0, force_busy = 1'b0, cmd_pend = 1'b0;

  // observations
  int sf_cnt, rac_cnt, done_cnt, tf_cnt, rac_cyc, done_cyc, acc_cyc;
  int sf_cyc[$];
  int idx_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int qs(input int k);
    return (k < sf_cyc.size()) ? sf_cyc[k] : -1;
  endfunction

  function automatic int qi(input int k);
    return (k < idx_q.size()) ? idx_q[k] : -1;
  endfunction

  task automatic clr();
    sf_cnt = 0; rac_cnt = 0; done_cnt = 0; tf_cnt = 0;
    rac_cyc = -1; done_cyc = -1; acc_cyc = -1;
    sf_cyc.delete();
    idx_q.delete();
  endtask

  task automatic send(input logic [2:0] sel, input logic ctrl, input logic [9:0] num,
                      input logic rp);
    bus.cmd_buffer_sel = sel;
    bus.cmd_tiles_ctrl = ctrl;
    bus.cmd_num_tiles  = num;
    bus.cmd_reset_ptr  = rp;
    cmd_pend           = 1'b1;
  endtask

  // Each iteration drives inputs for the next rising edge and observes the
  // outputs produced by the previous one.
  task automatic run_cycles(input int n, input bit stop_on_done);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      cyc++;
      bus.cmd_valid = cmd_pend;
      fetch_done    = (cyc == done_at) || (cyc == spur_at);
      fetch_busy    = force_busy || (cyc <= busy_until);
      tile_consumed = 1'b0;
      if (cyc == consume_at) begin
        tile_consumed = 1'b1;
      end else if (auto_ack && ack_q.size() > 0 && ack_q[0] == cyc) begin
        tile_consumed = 1'b1;
        void'(ack_q.pop_front());
      end else if (pend_consume > 0) begin
        tile_consumed = 1'b1;
        pend_consume--;
      end
      #1;
      if (cmd_pend && bus.cmd_ready) begin
        cmd_pend = 1'b0;
        acc_cyc  = cyc;
      end
      if (start_fetch) begin
        sf_cnt++;
        sf_cyc.push_back(cyc);
        done_at    = cyc + n_rd + 1;
        busy_until = cyc + n_rd + 1;
      end
      if (reset_addr_counter) begin
        rac_cnt++;
        rac_cyc = cyc;
      end
      if (tile_fetched) begin
        tf_cnt++;
        idx_q.push_back(int'(tile_idx));
        if (auto_ack) ack_q.push_back(cyc + ack_delay);
      end
      if (seq_done) begin
        done_cnt++;
        done_cyc = cyc;
        if (stop_on_done) break;
      end
    end
  endtask

  initial begin
    rst_n              = 1'b0;
    bus.cmd_valid      = 1'b0;
    bus.cmd_buffer_sel = '0;
    bus.cmd_tiles_ctrl = 1'b0;
    bus.cmd_num_tiles  = '0;
    bus.cmd_reset_ptr  = 1'b0;
    fetch_done         = 1'b0;
    fetch_busy         = 1'b0;
    tile_consumed      = 1'b0;
    clr();

    // reset state
    repeat (2) @(negedge clk);
    #1;
    check("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    check("rst_seq_busy", 32'(seq_busy), 32'd0);
    check("rst_pulses", 32'({start_fetch, reset_addr_counter, seq_done, tile_fetched}), 32'd0);
    check("rst_tile_idx", 32'(tile_idx), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_levels", 32'({Buffer_Select, Tiles_Control}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // basic weights run: 32-read tiles, pointer rewind, ack 5 cycles after each tile
    clr(); n_rd = 32; auto_ack = 1'b1; ack_delay = 5;
    send(3'd0, 1'b1, 10'd3, 1'b1);
    run_cycles(200, 1'b1);
    check("w_rac_cnt", 32'(rac_cnt), 32'd1);
    check("w_rac_lat", 32'(rac_cyc), 32'(acc_cyc + 1));
    check("w_sf_cnt", 32'(sf_cnt), 32'd3);
    check("w_sf0_lat", 32'(qs(0)), 32'(acc_cyc + 2));
    check("w_sf_gap1", 32'(qs(1) - qs(0)), 32'd34);
    check("w_sf_gap2", 32'(qs(2) - qs(1)), 32'd34);
    check("w_idx0", 32'(qi(0)), 32'd0);
    check("w_idx1", 32'(qi(1)), 32'd1);
    check("w_idx2", 32'(qi(2)), 32'd2);
    check("w_done_cnt", 32'(done_cnt), 32'd1);
    check("w_done_cyc", 32'(done_cyc), 32'(qs(2) + 41));
    check("w_levels", 32'({Buffer_Select, Tiles_Control}), 32'({3'd0, 1'b1}));
    check("w_err", 32'(err), 32'd0);

    // backpressure: four tiles, storage of two, no consumption
    clr(); n_rd = 4; auto_ack = 1'b0;
    send(3'd4, 1'b0, 10'd4, 1'b0);
    run_cycles(60, 1'b0);
    check("bp_sf_stall", 32'(sf_cnt), 32'd2);
    check("bp_tf_stall", 32'(tf_cnt), 32'd2);
    check("bp_busy", 32'({seq_busy, bus.cmd_ready}), 32'b10);
    pend_consume = 1;
    run_cycles(30, 1'b0);
    check("bp_sf_after1", 32'(sf_cnt), 32'd3);
    pend_consume = 1;
    run_cycles(30, 1'b0);
    check("bp_sf_after2", 32'(sf_cnt), 32'd4);
    check("bp_idx3", 32'(qi(3)), 32'd3);
    pend_consume = 1;
    run_cycles(20, 1'b0);
    check("bp_no_done_3", 32'(done_cnt), 32'd0);
    pend_consume = 1;
    run_cycles(20, 1'b1);
    check("bp_done_4", 32'(done_cnt), 32'd1);
    check("bp_levels", 32'({Buffer_Select, Tiles_Control}), 32'({3'd4, 1'b0}));
    check("bp_err", 32'(err), 32'd0);

    // zero-length command: straight to completion, rewind request ignored
    clr();
    send(3'd2, 1'b1, 10'd0, 1'b1);
    run_cycles(10, 1'b1);
    check("z_done_lat", 32'(done_cyc), 32'(acc_cyc + 1));
    check("z_no_pulses", 32'(sf_cnt + rac_cnt), 32'd0);
    check("z_levels", 32'({Buffer_Select, Tiles_Control}), 32'({3'd2, 1'b1}));
    check("z_err", 32'(err), 32'd0);

    // consume coincides with the second issue while one tile is outstanding
    clr(); n_rd = 4; auto_ack = 1'b0;
    consume_at = cyc + 8;
    send(3'd1, 1'b0, 10'd2, 1'b0);
    run_cycles(30, 1'b0);
    consume_at = -1;
    check("sim_sf_cnt", 32'(sf_cnt), 32'd2);
    check("sim_coincide", 32'(qs(1)), 32'(acc_cyc + 7));
    check("sim_still_one", 32'(done_cnt), 32'd0);
    pend_consume = 1;
    run_cycles(20, 1'b1);
    check("sim_done", 32'(done_cnt), 32'd1);
    check("sim_err", 32'(err), 32'd0);

    // error flags: spurious fetch_done while held in ISSUE, then stray consume
    clr(); n_rd = 4; force_busy = 1'b1;
    spur_at = cyc + 4;
    send(3'd3, 1'b0, 10'd1, 1'b0);
    run_cycles(8, 1'b0);
    spur_at = -1;
    check("e_err01", 32'(err), 32'd1);
    check("e_hold_issue", 32'({seq_busy, 1'(sf_cnt), 1'(tf_cnt)}), 32'b100);
    force_busy = 1'b0; auto_ack = 1'b1; ack_delay = 2;
    run_cycles(30, 1'b1);
    check("e_resume_sf", 32'(sf_cnt), 32'd1);
    check("e_resume_idx", 32'(qi(0)), 32'd0);
    check("e_resume_done", 32'(done_cnt), 32'd1);
    pend_consume = 1;
    run_cycles(2, 1'b0);
    check("e_err11", 32'(err), 32'd3);

    // reset while waiting on the third tile's fetch_done
    clr(); n_rd = 4; auto_ack = 1'b1; ack_delay = 2;
    send(3'd5, 1'b1, 10'd3, 1'b1);
    for (int k = 0; k < 100 && sf_cnt < 3; k++) run_cycles(1, 1'b0);
    run_cycles(2, 1'b0);
    check("r_pre_idx", 32'(tile_idx), 32'd1);
    @(negedge clk);
    rst_n         = 1'b0;
    fetch_done    = 1'b0;
    fetch_busy    = 1'b0;
    tile_consumed = 1'b0;
    bus.cmd_valid = 1'b0;
    #1;
    check("r_pulses", 32'({start_fetch, reset_addr_counter, seq_done, tile_fetched}), 32'd0);
    check("r_busy_ready", 32'({seq_busy, bus.cmd_ready}), 32'b01);
    check("r_idx", 32'(tile_idx), 32'd0);
    check("r_err", 32'(err), 32'd0);
    check("r_levels", 32'({Buffer_Select, Tiles_Control}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    done_at = -1; busy_until = -1; ack_q.delete();
    clr();
    send(3'd1, 1'b0, 10'd1, 1'b0);
    run_cycles(40, 1'b1);
    check("r2_sf0_lat", 32'(qs(0)), 32'(acc_cyc + 1));
    check("r2_counts", 32'({8'(sf_cnt), 8'(rac_cnt), 8'(tf_cnt), 8'(done_cnt)}),
          32'h01_00_01_01);
    check("r2_idx", 32'(qi(0)), 32'd0);
    check("r2_levels", 32'({Buffer_Select, Tiles_Control}), 32'({3'd1, 1'b0}));
    check("r2_err", 32'(err), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
